// File: rtl/demux1x4_reg.sv
// Registered 1-to-4 demultiplexer with one-entry output slots and valid/ready handshakes.
// Each slot drains independently and has its own wrapping transfer counter.
module demux1x4_reg #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] y0_o,
    output logic [DATA_W-1:0] y1_o,
    output logic [DATA_W-1:0] y2_o,
    output logic [DATA_W-1:0] y3_o,
    output logic              valid0_o,
    output logic              valid1_o,
    output logic              valid2_o,
    output logic              valid3_o,
    input  logic              ready0_i,
    input  logic              ready1_i,
    input  logic              ready2_i,
    input  logic              ready3_i,
    output logic [CNT_W-1:0]  cnt0_o,
    output logic [CNT_W-1:0]  cnt1_o,
    output logic [CNT_W-1:0]  cnt2_o,
    output logic [CNT_W-1:0]  cnt3_o
);

    logic [3:0]        full;
    logic [3:0]        rdy_vec;
    logic [3:0]        drain;
    logic [3:0]        load;
    logic              accept;
    logic [DATA_W-1:0] data [4];
    logic [CNT_W-1:0]  cnt  [4];

    assign rdy_vec = {ready3_i, ready2_i, ready1_i, ready0_i};
    assign drain   = full & rdy_vec;

    // A slot can take a new beat if empty or if it is being drained this same cycle.
    assign ready_o = !full[sel_i] || rdy_vec[sel_i];
    assign accept  = valid_i && ready_o;

    always_comb begin
        load = '0;
        if (accept) begin
            load[sel_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full <= '0;
            for (int k = 0; k < 4; k++) begin
                data[k] <= '0;
                cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data[k] <= x_i;
                    full[k] <= 1'b1;
                end else if (drain[k]) begin
                    full[k] <= 1'b0;
                end
                if (drain[k]) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign y0_o     = data[0];
    assign y1_o     = data[1];
    assign y2_o     = data[2];
    assign y3_o     = data[3];
    assign valid0_o = full[0];
    assign valid1_o = full[1];
    assign valid2_o = full[2];
    assign valid3_o = full[3];
    assign cnt0_o   = cnt[0];
    assign cnt1_o   = cnt[1];
    assign cnt2_o   = cnt[2];
    assign cnt3_o   = cnt[3];

endmodule

// File: tb/tb_demux1x4_reg.sv
// Directed bench for demux1x4_reg: handshake, backpressure, parallel drain, counter wrap, async reset.
module tb_demux1x4_reg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk_i;
    logic              rst_i;
    logic [1:0]        sel_i;
    logic [DATA_W-1:0] x_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] y0_o, y1_o, y2_o, y3_o;
    logic              valid0_o, valid1_o, valid2_o, valid3_o;
    logic              ready0_i, ready1_i, ready2_i, ready3_i;
    logic [CNT_W-1:0]  cnt0_o, cnt1_o, cnt2_o, cnt3_o;

    int total = 0;
    int bad   = 0;

    demux1x4_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .x_i(x_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .y0_o(y0_o), .y1_o(y1_o), .y2_o(y2_o), .y3_o(y3_o),
        .valid0_o(valid0_o), .valid1_o(valid1_o), .valid2_o(valid2_o), .valid3_o(valid3_o),
        .ready0_i(ready0_i), .ready1_i(ready1_i), .ready2_i(ready2_i), .ready3_i(ready3_i),
        .cnt0_o(cnt0_o), .cnt1_o(cnt1_o), .cnt2_o(cnt2_o), .cnt3_o(cnt3_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
    endtask

    function automatic logic [3:0] vld_vec();
        return {valid3_o, valid2_o, valid1_o, valid0_o};
    endfunction

    initial begin
        rst_i   = 1'b1;
        sel_i   = 2'd0;
        x_i     = '0;
        valid_i = 1'b0;
        {ready3_i, ready2_i, ready1_i, ready0_i} = 4'b0000;
        tick();
        tick();
        chk("rst_valids", 32'(vld_vec()), 32'h0);
        chk("rst_ready",  32'(ready_o), 32'h1);
        chk("rst_y0",     32'(y0_o), 32'h0);
        chk("rst_cnt3",   32'(cnt3_o), 32'h0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_ready", 32'(ready_o), 32'h1);

        // Single beat to output 2, drained the following cycle
        sel_i = 2'b10; x_i = 8'hA5; valid_i = 1'b1; ready2_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("t1_y2",     32'(y2_o), 32'hA5);
        chk("t1_valids", 32'(vld_vec()), 32'b0100);
        tick();
        chk("t1_valid2_after", 32'(valid2_o), 32'h0);
        chk("t1_cnt2",         32'(cnt2_o), 32'h1);
        ready2_i = 1'b0;

        // Backpressure on output 1, then simultaneous drain and refill
        pulse_reset();
        ready1_i = 1'b0;
        sel_i = 2'b01; x_i = 8'h11; valid_i = 1'b1;
        #1;
        chk("t2_ready_empty", 32'(ready_o), 32'h1);
        tick();
        x_i = 8'h22;
        #1;
        chk("t2_ready_full", 32'(ready_o), 32'h0);
        chk("t2_y1_11",      32'(y1_o), 32'h11);
        tick();
        chk("t2_y1_held",     32'(y1_o), 32'h11);
        chk("t2_valid1_held", 32'(valid1_o), 32'h1);
        chk("t2_cnt1_zero",   32'(cnt1_o), 32'h0);
        ready1_i = 1'b1;
        #1;
        chk("t2_ready_drain", 32'(ready_o), 32'h1);
        tick();
        valid_i = 1'b0;
        chk("t2_y1_22",   32'(y1_o), 32'h22);
        chk("t2_valid1",  32'(valid1_o), 32'h1);
        chk("t2_cnt1_1",  32'(cnt1_o), 32'h1);
        tick();
        chk("t2_valid1_empty", 32'(valid1_o), 32'h0);
        chk("t2_cnt1_2",       32'(cnt1_o), 32'h2);
        chk("t2_y1_hold",      32'(y1_o), 32'h22);
        ready1_i = 1'b0;

        // Fill all four slots, then drain them together
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            sel_i = 2'(k); x_i = 8'(k); valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        chk("t3_valids_full", 32'(vld_vec()), 32'b1111);
        chk("t3_y0", 32'(y0_o), 32'h0);
        chk("t3_y1", 32'(y1_o), 32'h1);
        chk("t3_y2", 32'(y2_o), 32'h2);
        chk("t3_y3", 32'(y3_o), 32'h3);
        {ready3_i, ready2_i, ready1_i, ready0_i} = 4'b1111;
        tick();
        {ready3_i, ready2_i, ready1_i, ready0_i} = 4'b0000;
        chk("t3_valids_empty", 32'(vld_vec()), 32'b0000);
        chk("t3_cnts", {16'h0, cnt3_o, cnt2_o, cnt1_o, cnt0_o}, 32'h1111);

        // A stalled slot must not block other destinations
        pulse_reset();
        sel_i = 2'b11; x_i = 8'h33; valid_i = 1'b1;
        tick();
        sel_i = 2'b00; x_i = 8'h44;
        #1;
        chk("t4_ready_sel0", 32'(ready_o), 32'h1);
        tick();
        chk("t4_y0",     32'(y0_o), 32'h44);
        chk("t4_valid0", 32'(valid0_o), 32'h1);
        sel_i = 2'b11; x_i = 8'h55;
        #1;
        chk("t4_ready_sel3", 32'(ready_o), 32'h0);
        tick();
        valid_i = 1'b0;
        chk("t4_y3_unchanged", 32'(y3_o), 32'h33);
        chk("t4_valid3",       32'(valid3_o), 32'h1);

        // Counter wrap on output 0, then asynchronous reset with a held beat
        pulse_reset();
        ready0_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel_i = 2'b00; x_i = 8'(i); valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        chk("t5_cnt0_15", 32'(cnt0_o), 32'hF);
        chk("t5_y0_last", 32'(y0_o), 32'hF);
        tick();
        chk("t5_cnt0_wrap",  32'(cnt0_o), 32'h0);
        chk("t5_valid0_end", 32'(valid0_o), 32'h0);
        sel_i = 2'b00; x_i = 8'hD7; valid_i = 1'b1;
        tick();
        x_i = 8'hC3;
        tick();
        valid_i = 1'b0; ready0_i = 1'b0;
        chk("t5_y0_c3",   32'(y0_o), 32'hC3);
        chk("t5_cnt0_1",  32'(cnt0_o), 32'h1);
        chk("t5_v0_full", 32'(valid0_o), 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t5_arst_valid0", 32'(valid0_o), 32'h0);
        chk("t5_arst_y0",     32'(y0_o), 32'h0);
        chk("t5_arst_cnt0",   32'(cnt0_o), 32'h0);
        chk("t5_arst_ready",  32'(ready_o), 32'h1);
        sel_i = 2'b01; x_i = 8'h99; valid_i = 1'b1;
        tick();
        chk("t5_no_accept_in_rst", 32'(valid1_o), 32'h0);
        rst_i = 1'b0;
        tick();
        valid_i = 1'b0;
        chk("t5_resume_y1",     32'(y1_o), 32'h99);
        chk("t5_resume_valid1", 32'(valid1_o), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
